mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's data/instruction bus. It accepts one request at a time from the core's address/write path.
- Each request is held for a programmable number of wait states, then committed to an internal word array with byte-lane write strobes.
- Completion is reported with a single-cycle response pulse carrying read data and an error flag.
- Sits between the core datapath and the unified memory; replaces the zero-latency memory model so control-FSM stall handling can be exercised.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; valid byte addresses 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 1, wait-state cycles between request acceptance and response (0..15).
- INIT_FILE, "", optional hex image loaded at elaboration; empty means contents undefined.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte-lane enables; bit i writes req_wdata[8i+7:8i]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data, valid only with rsp_valid
- rsp_err  out  1  access error, valid only with rsp_valid

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 in any cycle where reset=1.
  - Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (when reset=0).
  - On req_valid&&req_ready, capture we/addr/wdata/wstrb, load counter=WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 1, go to RESP.
  - The core must hold nothing; request fields are ignored outside IDLE.
- RESP (one cycle):
  - rsp_valid=1, req_ready=0; next state is IDLE.
  - rsp_valid, rsp_rdata and rsp_err are registered: they are set on the edge entering RESP and cleared on the edge leaving it.
- Latency:
  - A request accepted on edge N produces rsp_valid high in the cycle after edge N+1+WAIT_CYCLES.
  - Next acceptance is possible WAIT_CYCLES+2 cycles after the previous one.
- Error detection (evaluated on the captured request): rsp_err=1 if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS.
  - On error: no array write, rsp_rdata=0.
- Reads: rsp_rdata = array[addr[31:2]], the full word regardless of wstrb.
- Writes:
  - Committed on the same edge that raises rsp_valid, only for lanes with wstrb[i]=1.
  - rsp_rdata=0 for writes.
  - we=1 with wstrb=0: no change, rsp_err=0.
- Ordering: a read issued after a write response returns the written data; there is no internal buffering beyond one transaction.
- Reset mid-operation (in WAIT or RESP): the pending transaction is dropped, no write occurs, and rsp_valid is forced 0 from the next cycle.
- No response back-pressure: the core must accept rsp_valid in the cycle it is asserted.

Test Plan:
- Reset: hold reset 3 cycles, then release -> req_ready=0 during reset, 1 the cycle after release; rsp_valid=0 throughout.
- Write/read (WAIT_CYCLES=1):
  - Write 0xDEADBEEF to 0x10 with wstrb=1111 accepted at cycle 0 -> rsp_valid at cycle 2, rsp_err=0.
  - Then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte lanes:
  - With word 0x10 = 0xDEADBEEF, write 0x11223344 with wstrb=0101 -> a read returns 0xDE22BE44.
  - Write with wstrb=0000 -> word unchanged.
- Errors:
  - Read at 0x13 -> rsp_err=1, rsp_rdata=0.
  - Write to 4*DEPTH_WORDS -> rsp_err=1, and array word 0 is unchanged (no wrap).
- Latency sweep: WAIT_CYCLES=0, 3, 15 -> rsp_valid exactly 1, 4 and 16 cycles after acceptance. Back-to-back requests are spaced WAIT_CYCLES+2 cycles apart, with req_ready low in between.
- Reset mid-write (WAIT_CYCLES=3): accept a write of 0xCAFEF00D to 0x20, assert reset in the 2nd WAIT cycle -> no rsp_valid, and a later read of 0x20 returns the old value.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one request at a time, holds it for
// WAIT_CYCLES cycles, then commits it and pulses a registered response.
module mem_responder #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept, commit;
    logic          cur_we, cur_err;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_wstrb;
    logic [AW-1:0] cur_idx;

    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        accept    = req_valid && req_ready;

        // With zero wait states the commit happens on the accepting edge,
        // so the live request fields are used instead of the captured ones.
        cur_we    = (state_q == IDLE) ? req_we    : we_q;
        cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        cur_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;
        cur_err   = (cur_addr[1:0] != 2'b00) ||
                    ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
        cur_idx   = cur_addr[AW+1:2];

        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err;
            rsp_rdata_d = (!cur_we && !cur_err) ? mem_q[cur_idx] : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) mem_q[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with different wait states, checked
// against an array-based reference model with directed and random traffic.
module tb_mem_responder;
    localparam int N  = 4;
    localparam int DW = 64;

    int ws [N] = '{1, 0, 3, 15};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];
    logic        rsp_valid [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DW),
            .WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15),
            .INIT_FILE  ("")
        ) u_dut (
            .clk      (clk),
            .reset    (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_wstrb(req_wstrb[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mdl [N][DW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one request and collect its response; gap_ok covers ready low
    // while busy, ready back the cycle after the pulse, and a 1-cycle pulse.
    task automatic bus(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int lat, output logic gap_ok);
        int t = 0;
        while (!req_ready[d] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("ready_timeout", 32'(t < 50), 32'd1);
        req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_wstrb[d] = st;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_wstrb[d] = 4'($urandom);
        lat = 1; gap_ok = 1'b1;
        while (!rsp_valid[d] && lat < 40) begin
            if (req_ready[d]) gap_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (req_ready[d]) gap_ok = 1'b0;
        rd = rsp_rdata[d]; er = rsp_err[d];
        @(posedge clk); #1;
        if (!req_ready[d] || rsp_valid[d]) gap_ok = 1'b0;
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er);
        logic        exp_err, gap_ok;
        logic [31:0] exp_rd;
        int          lat, idx;
        exp_err = (a % 4 != 0) || (a / 4 >= DW);
        idx     = exp_err ? 0 : int'(a / 4);
        exp_rd  = (we || exp_err) ? 32'h0 : mdl[d][idx];
        bus(d, we, a, wd, st, rd, er, lat, gap_ok);
        chk("latency", lat, ws[d] + 1);
        chk("spacing", 32'(gap_ok), 32'd1);
        chk("rsp_err", 32'(er), 32'(exp_err));
        chk("rsp_rdata", rd, exp_rd);
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er, seen;
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_wstrb[d] = 4'h0;
        end

        repeat (3) begin
            @(posedge clk); #1;
            for (int d = 0; d < N; d++) begin
                chk("reset_ready", 32'(req_ready[d]), 32'd0);
                chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            end
        end
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < N; d++) chk("ready_after_reset", 32'(req_ready[d]), 32'd1);

        // Directed: WAIT_CYCLES=1 instance
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        chk("wr_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("rd_full", rd, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er);
        chk("rd_lanes", rd, 32'hDE22BE44);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er);
        chk("nostrb_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        chk("rd_nostrb", rd, 32'hDE22BE44);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'h0);
        txn(0, 1'b1, 32'h0, 32'h01234567, 4'hF, rd, er);
        txn(0, 1'b1, 32'(4 * DW), 32'hAAAAAAAA, 4'hF, rd, er);
        chk("oob_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        chk("no_wrap", rd, 32'h01234567);

        // Latency sweep on WAIT_CYCLES = 0, 3, 15
        for (int d = 1; d < N; d++) begin
            a = 32'h14 + 32'(4 * d);
            txn(d, 1'b1, a, 32'hA5000000 + 32'(d), 4'hF, rd, er);
            txn(d, 1'b0, a, 32'h0, 4'h0, rd, er);
            chk("sweep_rd", rd, 32'hA5000000 + 32'(d));
        end

        // Reset during the 2nd wait cycle of a write (WAIT_CYCLES=3)
        txn(2, 1'b1, 32'h20, 32'h11110000, 4'hF, rd, er);
        req_we[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'hCAFEF00D;
        req_wstrb[2] = 4'hF; req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        if (rsp_valid[2]) seen = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(req_ready[2]), 32'd0);
        rst[2] = 1'b0;
        repeat (6) begin
            if (rsp_valid[2]) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        txn(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        chk("midrst_old", rd, 32'h11110000);

        // Random traffic on WAIT_CYCLES=1 instance after filling the array
        for (int w = 0; w < DW; w++) txn(0, 1'b1, 32'(4 * w), $urandom, 4'hF, rd, er);
        for (int k = 0; k < 200; k++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 7)       a = {24'h0, 6'($urandom_range(0, DW - 1)), 2'b00};
            else if (r == 7) a = {24'h0, 6'($urandom_range(0, DW - 1)), 2'($urandom_range(1, 3))};
            else if (r == 8) a = 32'(4 * DW) + 32'(4 * $urandom_range(0, 63));
            else             a = $urandom;
            txn(0, 1'($urandom), a, $urandom, 4'($urandom), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
